// File: rtl/fm6126_init_seq.sv
// FM6126A-class register-init sequencer: shifts REG1/REG2 words into every
// driver chip of the chain and owns the panel bus while doing so.
module fm6126_init_seq #(
  parameter int          PANEL_WIDTH = 64,
  parameter int          CHAINS      = 1,
  parameter logic [15:0] REG1_VALUE  = 16'h7FFF,
  parameter logic [15:0] REG2_VALUE  = 16'h0040,
  parameter int          REG1_LATCH  = 11,
  parameter int          REG2_LATCH  = 12,
  parameter int          CLK_DIV     = 1,
  parameter int          GAP_CYCLES  = 4,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mask_en,
  output logic                  clk_out,
  output logic [3*CHAINS-1:0]   rgb1_out,
  output logic [3*CHAINS-1:0]   rgb2_out,
  output logic                  latch_out,
  output logic                  output_enable_out,
  output logic                  busy,
  output logic                  done
);

  if (PANEL_WIDTH < 16 || (PANEL_WIDTH % 16) != 0) begin : g_bad_width
    $error("PANEL_WIDTH must be a multiple of 16 and >= 16");
  end
  if (REG1_LATCH < 1 || REG1_LATCH > PANEL_WIDTH) begin : g_bad_l1
    $error("REG1_LATCH out of range");
  end
  if (REG2_LATCH < 1 || REG2_LATCH > PANEL_WIDTH) begin : g_bad_l2
    $error("REG2_LATCH out of range");
  end
  if (CLK_DIV < 1 || GAP_CYCLES < 1) begin : g_bad_timing
    $error("CLK_DIV and GAP_CYCLES must be >= 1");
  end

  localparam int CW  = $clog2(PANEL_WIDTH);
  localparam int PHW = $clog2(2 * CLK_DIV);
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(PANEL_WIDTH - 1);
  localparam logic [CW-1:0]  L1_FROM  = CW'(PANEL_WIDTH - REG1_LATCH);
  localparam logic [CW-1:0]  L2_FROM  = CW'(PANEL_WIDTH - REG2_LATCH);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_HIGH  = PHW'(CLK_DIV);
  localparam logic [GW-1:0]  G_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, SHIFT1, GAP1, SHIFT2, GAP2, DONE
  } state_t;

  state_t         state, state_n;
  logic [GW-1:0]  gcnt, gcnt_n;
  logic [CW-1:0]  col, col_n;
  logic [PHW-1:0] ph, ph_n;
  logic           hold;

  // hold keeps the reset interval itself from counting as a PREP cycle
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= AUTO_START ? PREP : IDLE;
      gcnt  <= '0;
      col   <= '0;
      ph    <= '0;
      hold  <= 1'b1;
    end else begin
      state <= state_n;
      gcnt  <= gcnt_n;
      col   <= col_n;
      ph    <= ph_n;
      hold  <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    col_n   = col;
    ph_n    = ph;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = PREP;
          gcnt_n  = '0;
        end
      end
      PREP, GAP1, GAP2: begin
        if (!hold) begin
          if (gcnt == G_LAST) begin
            gcnt_n = '0;
            col_n  = '0;
            ph_n   = '0;
            if (state == PREP)      state_n = SHIFT1;
            else if (state == GAP1) state_n = SHIFT2;
            else                    state_n = DONE;
          end else begin
            gcnt_n = gcnt + 1'b1;
          end
        end
      end
      SHIFT1, SHIFT2: begin
        if (ph == PH_LAST) begin
          ph_n = '0;
          if (col == COL_LAST) begin
            col_n   = '0;
            gcnt_n  = '0;
            state_n = (state == SHIFT1) ? GAP1 : GAP2;
          end else begin
            col_n = col + 1'b1;
          end
        end else begin
          ph_n = ph + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic        act_n, shift_n, data_n, lat_n, clk_n;
  logic [15:0] word;
  logic [CW-1:0] lfrom;
  logic [3:0]  bi;

  // outputs are registered from the next state so they never glitch
  always_comb begin
    act_n   = 1'b0;
    shift_n = 1'b0;
    word    = REG1_VALUE;
    lfrom   = L1_FROM;
    bi      = 4'd15 - col_n[3:0];
    unique case (state_n)
      PREP, GAP1, GAP2: act_n = 1'b1;
      SHIFT1: begin
        act_n   = 1'b1;
        shift_n = 1'b1;
      end
      SHIFT2: begin
        act_n   = 1'b1;
        shift_n = 1'b1;
        word    = REG2_VALUE;
        lfrom   = L2_FROM;
      end
      default: act_n = 1'b0;
    endcase
    data_n = shift_n & word[bi];
    lat_n  = shift_n & (col_n >= lfrom);
    clk_n  = shift_n & (ph_n >= PH_HIGH);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mask_en           <= AUTO_START;
      output_enable_out <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      clk_out           <= 1'b0;
      latch_out         <= 1'b0;
      rgb1_out          <= '0;
      rgb2_out          <= '0;
    end else begin
      mask_en           <= act_n;
      output_enable_out <= act_n;
      busy              <= act_n;
      done              <= (state_n == DONE);
      clk_out           <= clk_n;
      latch_out         <= lat_n;
      rgb1_out          <= {(3 * CHAINS){data_n}};
      rgb2_out          <= {(3 * CHAINS){data_n}};
    end
  end

endmodule

// File: tb/tb_fm6126_init_seq.sv
// Scoreboard bench for fm6126_init_seq: a default instance and a
// two-chain, divided-clock, manual-start instance.
module tb_fm6126_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, st_a, st_b, nz_a, nz_b, start_a, start_b;
  logic mask_a, clk_a, lat_a, oe_a, busy_a, done_a;
  logic mask_b, clk_b, lat_b, oe_b, busy_b, done_b;
  logic [2:0] rgb1_a, rgb2_a;
  logic [5:0] rgb1_b, rgb2_b;
  logic noise_on;

  assign start_a = st_a | nz_a;
  assign start_b = st_b | nz_b;

  fm6126_init_seq u_a (
    .clk_in(clk), .reset(rst_a), .start(start_a),
    .mask_en(mask_a), .clk_out(clk_a),
    .rgb1_out(rgb1_a), .rgb2_out(rgb2_a),
    .latch_out(lat_a), .output_enable_out(oe_a),
    .busy(busy_a), .done(done_a)
  );

  fm6126_init_seq #(
    .PANEL_WIDTH(32), .CHAINS(2), .REG1_VALUE(16'hA5C3),
    .CLK_DIV(3), .AUTO_START(1'b0)
  ) u_b (
    .clk_in(clk), .reset(rst_b), .start(start_b),
    .mask_en(mask_b), .clk_out(clk_b),
    .rgb1_out(rgb1_b), .rgb2_out(rgb2_b),
    .latch_out(lat_b), .output_enable_out(oe_b),
    .busy(busy_b), .done(done_b)
  );

  int total = 0;
  int bad = 0;

  int qa[$], qb[$], qba[$], qbb[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every rising clk_out edge carries word bit 15-(c%16)
  // and latch for the last LATCH columns; busy spans 3 gaps + 4 half-word passes.
  task automatic push_seq(input int k);
    int pw, div, lat, e;
    logic [15:0] val;
    pw  = (k == 0) ? 64 : 32;
    div = (k == 0) ? 1 : 3;
    for (int r = 0; r < 2; r++) begin
      val = (r == 0) ? ((k == 0) ? 16'h7FFF : 16'hA5C3) : 16'h0040;
      lat = (r == 0) ? 11 : 12;
      for (int c = 0; c < pw; c++) begin
        e = 2 * int'((val >> (15 - (c % 16))) & 16'd1);
        e += (c >= pw - lat) ? 1 : 0;
        if (k == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
    if (k == 0) qba.push_back(3 * 4 + 4 * pw * div);
    else qbb.push_back(3 * 4 + 4 * pw * div);
  endtask

  bit pc[2], pb[2];
  int lo[2], hi[2], same[2], run[2], edges[2];
  logic [12:0] prev[2];

  task automatic mon(input int k, input bit r, input bit co,
                     input logic [5:0] d1, input logic [5:0] d2,
                     input int nb, input bit lat, input bit bz,
                     input bit mk, input bit oe, input bit dn);
    int div, e, ed, eb;
    logic [12:0] cur;
    div = (k == 0) ? 1 : 3;
    if (r) begin
      pc[k] = 0; pb[k] = 0; lo[k] = 0; hi[k] = 0;
      same[k] = 0; run[k] = 0; prev[k] = '0;
      return;
    end
    cur = {lat, d1, d2};
    same[k] = (cur == prev[k]) ? same[k] + 1 : 0;
    if (bz && !pb[k]) edges[k] = 0;
    if (co && !pc[k]) begin
      edges[k]++;
      chk("low_width", int'(lo[k] >= div), 1);
      chk("setup", int'(same[k] >= div), 1);
      if ((k == 0 ? qa.size() : qb.size()) == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        ed = (e >= 2) ? (1 << nb) - 1 : 0;
        chk("rgb1", int'(d1), ed);
        chk("rgb2", int'(d2), ed);
        chk("latch", int'(lat), e % 2);
      end
      hi[k] = 1;
    end else if (co) begin
      hi[k]++;
      chk("hold", int'(cur == prev[k]), 1);
    end else begin
      if (pc[k]) chk("high_width", hi[k], div);
      lo[k] = pc[k] ? 1 : lo[k] + 1;
    end
    chk("mask_vs_busy", int'(mk), int'(bz));
    chk("oe_vs_mask", int'(oe), int'(mk));
    if (bz) begin
      run[k]++;
      if (dn) chk("done_while_busy", int'(dn), 0);
    end else begin
      if (co || lat || d1 != 0 || d2 != 0) chk("idle_quiet", 1, 0);
      if (pb[k]) begin
        chk("done_rise", int'(dn), 1);
        if ((k == 0 ? qba.size() : qbb.size()) == 0) begin
          chk("busy_underflow", 1, 0);
        end else begin
          eb = (k == 0) ? qba.pop_front() : qbb.pop_front();
          chk("busy_len", run[k], eb);
        end
        run[k] = 0;
      end
    end
    pc[k] = co;
    pb[k] = bz;
    prev[k] = cur;
  endtask

  always @(negedge clk) begin
    mon(0, rst_a, clk_a, {3'b0, rgb1_a}, {3'b0, rgb2_a}, 3,
        lat_a, busy_a, mask_a, oe_a, done_a);
    mon(1, rst_b, clk_b, rgb1_b, rgb2_b, 6,
        lat_b, busy_b, mask_b, oe_b, done_b);
  end

  // random start pulses while busy must be ignored
  always @(negedge clk) begin
    nz_a = noise_on && busy_a && ($urandom_range(0, 7) == 0);
    nz_b = noise_on && busy_b && ($urandom_range(0, 7) == 0);
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_clk"}, int'(clk_a), 0);
    chk({tag, "_rgb"}, int'({rgb1_a, rgb2_a}), 0);
    chk({tag, "_lat"}, int'(lat_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_mask"}, int'(mask_a), 1);
    chk({tag, "_oe"}, int'(oe_a), 1);
  endtask

  task automatic wait_done(input int k, input int lim);
    int n;
    n = 0;
    while (!(k == 0 ? done_a : done_b) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(n < lim), 1);
    @(negedge clk);
    chk("sb_left", (k == 0) ? qa.size() : qb.size(), 0);
  endtask

  task automatic wait_edges(input int n);
    int t;
    t = 0;
    while (edges[0] < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("edge_timeout", int'(t < 1000), 1);
  endtask

  task automatic restart_a();
    @(negedge clk);
    st_a = 1'b1;
    push_seq(0);
    @(posedge clk);
    #1;
    chk("restart_done", int'(done_a), 0);
    chk("restart_busy", int'(busy_a), 1);
    chk("restart_mask", int'(mask_a), 1);
    @(negedge clk);
    st_a = 1'b0;
  endtask

  initial begin
    int col, quiet;
    rst_a = 1'b1; rst_b = 1'b1;
    st_a = 1'b0; st_b = 1'b0;
    nz_a = 1'b0; nz_b = 1'b0;
    noise_on = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst");
    chk("rst_b_mask", int'(mask_b), 0);
    chk("rst_b_oe", int'(oe_b), 1);
    chk("rst_b_busy", int'(busy_b), 0);
    push_seq(0);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    wait_edges(10);
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    noise_on = 1'b1;
    wait_done(0, 400);

    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      chk("done_hold", int'(done_a), 1);
      restart_a();
      wait_done(0, 400);
    end

    restart_a();
    col = $urandom_range(5, 60);
    wait_edges(64 + col);
    #2;
    rst_a = 1'b1;
    #1;
    chk_reset_a("midrst");
    qa.delete();
    qba.delete();
    repeat (3) @(negedge clk);
    push_seq(0);
    #1;
    rst_a = 1'b0;
    wait_done(0, 400);

    quiet = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (clk_b || mask_b || busy_b) quiet = 0;
    end
    chk("b_quiet", quiet, 1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      st_b = 1'b1;
      push_seq(1);
      @(posedge clk);
      #1;
      chk("b_start_busy", int'(busy_b), 1);
      chk("b_start_done", int'(done_b), 0);
      @(negedge clk);
      st_b = 1'b0;
      wait_done(1, 1000);
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    noise_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fm6126_init_seq.md
Name: fm6126_init_seq

Overview:
Parametrised FM6126A-class panel driver register-init sequencer.
- After reset, or on request, shifts two configuration words (REG1, REG2) into every driver chip in the chain. Each write is qualified by a latch window of register-specific length.
- Owns the panel bus while `mask_en` is high; the top-level mux selects this block's outputs over the normal scan engine during that time.
- Generalises the fixed single-chain init block: parametrised width, chain count, register values, latch lengths, clock division, plus start/busy/done handshake.

Parameters:
- PANEL_WIDTH, 64, columns per chain; multiple of 16, >= 16.
- CHAINS, 1, number of rgb1/rgb2 triplet pairs driven.
- REG1_VALUE, 16'h7FFF, word written to REG1.
- REG2_VALUE, 16'h0040, word written to REG2.
- REG1_LATCH, 11, trailing columns with latch high for REG1; range 1..PANEL_WIDTH.
- REG2_LATCH, 12, trailing columns with latch high for REG2; range 1..PANEL_WIDTH.
- CLK_DIV, 1, clk_in cycles per clk_out phase; >= 1.
- GAP_CYCLES, 4, idle clk_in cycles before, between and after writes; >= 1.
- AUTO_START, 1, run sequence automatically after reset release.

Ports:
- clk_in, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- start, input, 1, single-cycle request to (re)run the sequence.
- mask_en, output, 1, high while the sequencer owns the panel bus.
- clk_out, output, 1, panel shift clock.
- rgb1_out, output, 3*CHAINS, upper-half data lines.
- rgb2_out, output, 3*CHAINS, lower-half data lines.
- latch_out, output, 1, panel LAT.
- output_enable_out, output, 1, panel OE, active-low.
- busy, output, 1, sequence in progress.
- done, output, 1, sequence completed; held until the next start.

Behaviour:
- Reset values (asynchronous, immediate on reset assertion):
  - mask_en = AUTO_START; output_enable_out = 1.
  - clk_out, latch_out, rgb1_out, rgb2_out, busy, done = 0.
  - FSM = IDLE (AUTO_START=0) or PREP (AUTO_START=1).
- FSM states: IDLE -> PREP -> SHIFT1 -> GAP1 -> SHIFT2 -> GAP2 -> DONE.
  - IDLE/DONE -> PREP on start.
  - PREP, GAP1 and GAP2 each last GAP_CYCLES clk_in cycles.
- busy = 1 in PREP..GAP2. mask_en = 1 in PREP..GAP2.
- output_enable_out = 1 always while mask_en = 1; 0 in IDLE/DONE. The mux ignores it there.
- SHIFT phases: column index c = 0..PANEL_WIDTH-1. Each column occupies 2*CLK_DIV clk_in cycles:
  - First CLK_DIV cycles: clk_out = 0.
  - Next CLK_DIV cycles: clk_out = 1.
  - Data and latch change only on entry to the low phase, so they are stable across the clk_out rising edge.
- Data bit = REGn_VALUE[15 - (c mod 16)], replicated onto all 3*CHAINS bits of both rgb1_out and rgb2_out. The word is MSB-first and repeats per 16-column chip.
- latch_out = 1 for columns c >= PANEL_WIDTH - REGn_LATCH, else 0. It is cleared on entry to the following GAP state.
- In GAP/PREP/IDLE/DONE: clk_out = 0, latch_out = 0, rgb = 0.
- Cycle count:
  - Total busy cycles = 3*GAP_CYCLES + 4*PANEL_WIDTH*CLK_DIV.
  - done rises on the first DONE cycle, together with busy falling and mask_en falling.
- start handling:
  - start while busy: ignored.
  - start in DONE/IDLE: next cycle done = 0, busy = 1, mask_en = 1, FSM in PREP.
- Reset mid-operation: all outputs return to reset values at once. After release, the sequence restarts from PREP if AUTO_START, else waits in IDLE.
- Illegal parameter combinations raise an elaboration error:
  - PANEL_WIDTH not a multiple of 16.
  - REGn_LATCH outside 1..PANEL_WIDTH.
  - CLK_DIV = 0 or GAP_CYCLES = 0.
- Counters are sized with $clog2 of their maximum value; no wrap-around is reachable.

Test Plan:
- Defaults, reset pulse:
  - SHIFT1 yields exactly 64 clk_out rising edges; sampled data = 0x7FFF x4; latch high on edges 54..64.
  - SHIFT2 yields 0x0040 x4; latch high on edges 53..64.
  - done and busy/mask_en fall exactly 268 cycles after reset release.
- CLK_DIV=3, GAP_CYCLES=4:
  - clk_out shows 3 low / 3 high cycles.
  - Data is stable from 3 cycles before through 3 cycles after each rising edge.
  - Total busy = 780 cycles.
- Handshake:
  - start pulsed during SHIFT1: no effect, done still at cycle 268.
  - start pulsed in DONE: done = 0 and busy = 1 on the next cycle; full 268-cycle rerun with identical waveform.
- Reset asserted mid SHIFT2 (column 20):
  - Outputs hit reset values in the same cycle, without waiting for a clock edge.
  - After release, a complete sequence from PREP is re-emitted.
- CHAINS=2, PANEL_WIDTH=32, REG1_VALUE=16'hA5C3:
  - All 6 bits of rgb1_out and rgb2_out are equal at every rising edge.
  - Pattern 0xA5C3 x2; latch on edges 22..32.
- AUTO_START=0:
  - After reset: mask_en = 0, busy = 0, no clk_out activity for 1000 cycles.
  - A start pulse then produces the default sequence and done.
